alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter sharing the single combinational ALU between two requesters in the CPU (e.g. the execute stage and the address/branch-compare unit). It selects one request per cycle with round-robin priority, drives the ALU operands and control code, and captures the ALU result into a one-entry response register with a valid/ready handshake. The requester ID and a tag are returned so each consumer can claim its own result.

## Interface
- TAG_W, 4, width of the requester-supplied tag echoed with the result
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous reset, active low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  32  operands
- req0_ctrl  in  3  ALU control code
- req0_tag  in  TAG_W  opaque tag
- req1_valid / req1_ready / req1_a / req1_b / req1_ctrl / req1_tag  same as requester 0
- alu_a, alu_b  out  32  operands to ALU
- alu_ctrl  out  3  control code to ALU
- alu_result  in  32  combinational ALU result
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_result  out  32  captured result
- rsp_id  out  1  requester that issued the operation
- rsp_tag  out  TAG_W  echoed tag
- rsp_err  out  1  operation had an illegal control code

## Operation
- Legal ctrl codes: 000 AND, 001 OR, 010 ADD, 011 compare-vector, 110 SUB, 111 unsigned set-less-than. Codes 100 and 101 are illegal.
- can_accept = !rsp_valid | rsp_ready.
- Pointer `last` (1 bit) records the last granted requester.
- grant0 = req0_valid & (!req1_valid | last==1); grant1 = req1_valid & (!req0_valid | last==0). At most one grant per cycle.
- reqN_ready = can_accept & grantN (combinational; valid must not depend on ready).
- ALU mux: when grantN, alu_a/alu_b/alu_ctrl = reqN payload; with no grant, drive 0/0/3'b000. For an illegal code, drive alu_ctrl = 3'b000.
- On a clock edge with reqN_valid & reqN_ready: rsp_valid<=1, rsp_id<=N, rsp_tag<=reqN_tag, last<=N. For a legal code, rsp_err<=0 and rsp_result<=alu_result. For an illegal code, rsp_err<=1 and rsp_result<=0.
- On an edge with rsp_valid & rsp_ready and no new accept: rsp_valid<=0. The other rsp_* fields hold their value.
- Simultaneous consume and accept: the new result overwrites the register and rsp_valid stays 1.
- Backpressure: while rsp_valid & !rsp_ready, both readies are 0, rsp_* are stable and `last` is unchanged.
- Requesters hold their payload stable while valid & !ready.
- Fairness: a continuously valid requester is granted within 2 accepting cycles.

## Timing
- Reset (resetn=0 at an edge): rsp_valid=0, rsp_result=0, rsp_id=0, rsp_tag=0, rsp_err=0, last=1 (requester 0 wins the first tie).
- Reset overrides any in-flight accept or response. An unconsumed result is dropped.
- During reset, readies are 0. They are gated by resetn.
- Latency: accepted at edge N, result visible on rsp_* after edge N.
- Throughput: 1 op/cycle with rsp_ready held high, alternating requesters under contention.
- No combinational path from alu_result to any output.

## Test plan
- Reset then idle: all rsp_* = 0, both readies 0, alu_* = 0.
- Single op: req0 a=5, b=3, ctrl=110, tag=7, rsp_ready=1 -> req0_ready=1 same cycle. Next cycle rsp_valid=1, rsp_result=2, rsp_id=0, rsp_tag=7, rsp_err=0.
- Contention: both valid for 4 cycles with rsp_ready=1, req0 ADD 1+1, req1 OR 0xF0|0x0F -> grants in order 0,1,0,1. Responses alternate 2 and 0xFF with matching rsp_id.
- Backpressure: response pending, rsp_ready=0 for 3 cycles with both requesting -> readies 0 and rsp_* stable. Release rsp_ready -> accept and consume in the same cycle, rsp_valid stays 1 with the new result.
- Illegal code: req1 ctrl=101 -> rsp_err=1, rsp_result=0, alu_ctrl=000 during the grant. A following legal op clears rsp_err.
- Reset mid-stream: resetn=0 while rsp_valid=1 and both requests are pending -> next cycle rsp_valid=0. After release, req0 is granted first on a tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response carrying requester id, tag and error flag.
module alu_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_ctrl,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    logic             can_accept;
    logic             grant0, grant1;
    logic             accept;
    logic             illegal;
    logic [2:0]       sel_ctrl;
    logic [TAG_W-1:0] sel_tag;

    // last_q == 1 means requester 1 was granted last, so requester 0 wins a tie.
    always_comb begin
        can_accept = !rsp_valid_q || rsp_ready;
        grant0     = req0_valid && (!req1_valid || last_q);
        grant1     = req1_valid && (!req0_valid || !last_q);
        req0_ready = resetn && can_accept && grant0;
        req1_ready = resetn && can_accept && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        sel_ctrl = '0;
        sel_tag  = '0;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            sel_ctrl = req0_ctrl;
            sel_tag  = req0_tag;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            sel_ctrl = req1_ctrl;
            sel_tag  = req1_tag;
        end
        // Codes 100 and 101 are undefined; the ALU sees a harmless AND instead.
        illegal  = (sel_ctrl[2:1] == 2'b10);
        alu_ctrl = illegal ? 3'b000 : sel_ctrl;
    end

    always_comb begin
        last_d       = last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1;
            rsp_tag_d    = sel_tag;
            rsp_err_d    = illegal;
            rsp_result_d = illegal ? 32'd0 : alu_result;
            last_d       = grant1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q       <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_q       <= last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU closes the loop, accepted operations are
// queued as expected responses and compared when the response register updates.
module tb_alu_arbiter;

    localparam int unsigned TAG_W = 4;

    logic             clk;
    logic             resetn;
    logic             req0_valid, req0_ready;
    logic [31:0]      req0_a, req0_b;
    logic [2:0]       req0_ctrl;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [31:0]      req1_a, req1_b;
    logic [2:0]       req1_ctrl;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      alu_a, alu_b, alu_result;
    logic [2:0]       alu_ctrl;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    int checks = 0;
    int failures = 0;

    // {valid, id, tag, err, result}
    logic [38:0] sb[$];
    logic [38:0] rsp_vec;
    logic [38:0] exp_vec;
    logic [38:0] hold_vec;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .req1_tag   (req1_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return {29'd0, $signed(a) < $signed(b), a < b, a == b};
            3'b110:  return a - b;
            3'b111:  return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [38:0] expect_rsp(input logic id, input logic [31:0] a,
                                               input logic [31:0] b, input logic [2:0] c,
                                               input logic [TAG_W-1:0] tag);
        logic bad;
        bad = (c == 3'b100) || (c == 3'b101);
        return {1'b1, id, tag, bad, bad ? 32'd0 : alu_model(a, b, c)};
    endfunction

    function automatic logic [38:0] sb_next();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_ctrl);
    assign rsp_vec    = {rsp_valid, rsp_id, rsp_tag, rsp_err, rsp_result};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard push at the negedge before the accepting edge; returns at posedge + 1.
    task automatic tick();
        @(negedge clk);
        if (req0_valid && req0_ready)
            sb.push_back(expect_rsp(1'b0, req0_a, req0_b, req0_ctrl, req0_tag));
        if (req1_valid && req1_ready)
            sb.push_back(expect_rsp(1'b1, req1_a, req1_b, req1_ctrl, req1_tag));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_tag = '0;
        tick(); tick();
        checks++;
        if (rsp_vec !== 39'd0) begin
            failures++; $display("FAIL reset_rsp: got %h expected %h", rsp_vec, 39'd0);
        end
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
            failures++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_a, alu_b, alu_ctrl);
        end
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_ready_gate: got %b expected 00", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; resetn = 1'b1;
        tick();
        checks++;
        if (rsp_vec !== 39'd0 || sb.size() != 0) begin
            failures++; $display("FAIL idle_after_reset: got %h expected %h", rsp_vec, 39'd0);
        end
    endtask

    task automatic test_single();
        req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b110; req0_tag = 4'd7;
        req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, alu_a, alu_b, alu_ctrl} !== {2'b10, 32'd5, 32'd3, 3'b110}) begin
            failures++;
            $display("FAIL single_grant: got rdy=%b%b alu=%h %h %b expected rdy=10 alu=5 3 110",
                     req0_ready, req1_ready, alu_a, alu_b, alu_ctrl);
        end
        tick();
        req0_valid = 1'b0;
        exp_vec = sb_next();
        checks++;
        if (rsp_vec !== exp_vec || rsp_result !== 32'd2) begin
            failures++; $display("FAIL single_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL single_consume: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_contention();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 3'b010; req0_tag = 4'd1;
        req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 3'b001; req1_tag = 4'd2;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_grant%0d: got %b expected %b", i,
                         {req1_ready, req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
            end
            tick();
            exp_vec = sb_next();
            checks++;
            if (rsp_vec !== exp_vec || rsp_result !== ((i % 2 == 1) ? 32'hFF : 32'd2)) begin
                failures++; $display("FAIL contention_rsp%0d: got %h expected %h", i, rsp_vec, exp_vec);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = 3'b111; req0_tag = 4'd3;
        req0_valid = 1'b1; rsp_ready = 1'b0;
        tick();
        hold_vec = sb_next();
        checks++;
        if (rsp_vec !== hold_vec) begin
            failures++; $display("FAIL bp_first_rsp: got %h expected %h", rsp_vec, hold_vec);
        end
        req0_a = 32'd100; req0_b = 32'd1; req0_ctrl = 3'b010; req0_tag = 4'd4;
        req1_a = 32'h8000_0000; req1_b = 32'd1; req1_ctrl = 3'b110; req1_tag = 4'd9;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                failures++; $display("FAIL bp_ready%0d: got %b expected 00", i, {req1_ready, req0_ready});
            end
            tick();
            checks++;
            if (rsp_vec !== hold_vec || sb.size() != 0) begin
                failures++; $display("FAIL bp_stable%0d: got %h expected %h", i, rsp_vec, hold_vec);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failures++; $display("FAIL bp_release_grant: got %b expected 10", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_vec = sb_next();
        checks++;
        if (rsp_vec !== exp_vec || rsp_result !== 32'h7FFF_FFFF) begin
            failures++; $display("FAIL bp_overwrite: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
    endtask

    task automatic test_illegal();
        req1_a = 32'd9; req1_b = 32'd4; req1_ctrl = 3'b101; req1_tag = 4'd5;
        req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, alu_a, alu_ctrl} !== {1'b1, 32'd9, 3'b000}) begin
            failures++;
            $display("FAIL illegal_alu: got rdy=%b a=%h ctrl=%b expected rdy=1 a=9 ctrl=000",
                     req1_ready, alu_a, alu_ctrl);
        end
        tick();
        exp_vec = sb_next();
        checks++;
        if (rsp_vec !== exp_vec || {rsp_err, rsp_result} !== {1'b1, 32'd0}) begin
            failures++; $display("FAIL illegal_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        req1_a = 32'hFF; req1_b = 32'h0F; req1_ctrl = 3'b000; req1_tag = 4'd6;
        tick();
        req1_valid = 1'b0;
        exp_vec = sb_next();
        checks++;
        if (rsp_vec !== exp_vec || {rsp_err, rsp_result} !== {1'b0, 32'h0F}) begin
            failures++; $display("FAIL illegal_clear: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = 3'b011; req0_tag = 4'd8;
        req1_a = 32'd2; req1_b = 32'd3; req1_ctrl = 3'b010; req1_tag = 4'd11;
        req1_valid = 1'b1; rsp_ready = 1'b0;
        tick();
        exp_vec = sb_next();
        checks++;
        if (rsp_vec !== exp_vec) begin
            failures++; $display("FAIL mid_pending: got %h expected %h", rsp_vec, exp_vec);
        end
        req0_valid = 1'b1; resetn = 1'b0;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            failures++; $display("FAIL mid_reset_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        tick();
        checks++;
        if (rsp_vec !== 39'd0) begin
            failures++; $display("FAIL mid_reset_rsp: got %h expected %h", rsp_vec, 39'd0);
        end
        resetn = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++; $display("FAIL mid_tie_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_vec = sb_next();
        checks++;
        if (rsp_vec !== exp_vec || rsp_result !== 32'd1) begin
            failures++; $display("FAIL mid_first_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
